// File: rtl/ram_param_if.sv
// Bus bundle for ram_param: access request, wipe command and registered
// response/status. The master drives requests, the RAM (slave) drives status.
interface ram_param_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 1
);
   logic              en;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  data_in;
   logic              wipe;
   logic [WIDTH-1:0]  data_out;
   logic              valid;
   logic              busy;
   logic              err;

   modport master (
      output en, rw, addr, data_in, wipe,
      input  data_out, valid, busy, err
   );

   modport slave (
      input  en, rw, addr, data_in, wipe,
      output data_out, valid, busy, err
   );
endinterface

// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM (2**ADDR_W words of WIDTH bits).
// Reads are registered with a one-cycle valid strobe. A wipe sweep zeroes
// the whole array after reset and on request; accesses that arrive while the
// sweep runs are dropped and flagged with a one-cycle err pulse.
module ram_param #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 1
) (
   input  logic         clk,
   input  logic         clr,
   ram_param_if.slave   bus
);
   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_WIPE = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] w_wptr_nxt;

   // Storage has no reset: the sweep is what clears it.
   logic [WIDTH-1:0]  r_mem [DEPTH];

   logic [WIDTH-1:0]  r_dout;
   logic [WIDTH-1:0]  w_dout_nxt;
   logic              r_valid;
   logic              w_valid_nxt;
   logic              r_err;
   logic              w_err_nxt;
   logic              r_busy;
   logic              w_busy_nxt;

   // Single write port shared by the sweep and by normal writes.
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [WIDTH-1:0]  w_mem_wdata;

   // Next-state, memory write port and next registered outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_wptr_nxt  = r_wptr;
      w_dout_nxt  = r_dout;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = bus.addr;
      w_mem_wdata = bus.data_in;

      case (r_state)
         ST_WIPE: begin
            // Sweep one word per cycle; any access request is dropped.
            w_mem_we    = 1'b1;
            w_mem_addr  = r_wptr;
            w_mem_wdata = '0;
            w_err_nxt   = bus.en;
            if (r_wptr == LAST_ADDR) begin
               w_state_nxt = ST_IDLE;
               w_wptr_nxt  = '0;
            end else begin
               w_wptr_nxt  = r_wptr + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            // A wipe request wins over a simultaneous access, silently.
            if (bus.wipe) begin
               w_state_nxt = ST_WIPE;
               w_wptr_nxt  = '0;
            end else if (bus.en) begin
               if (bus.rw) begin
                  w_mem_we = 1'b1;
               end else begin
                  w_dout_nxt  = r_mem[bus.addr];
                  w_valid_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_WIPE;
            w_wptr_nxt  = '0;
         end
      endcase

      // busy is registered, so it follows the state we are about to enter.
      w_busy_nxt = (w_state_nxt == ST_WIPE);
   end

   // Control and output registers; reset starts a fresh sweep from word 0.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= ST_WIPE;
         r_wptr  <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_wptr  <= w_wptr_nxt;
         r_dout  <= w_dout_nxt;
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Memory array write.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   assign bus.data_out = r_dout;
   assign bus.valid    = r_valid;
   assign bus.busy     = r_busy;
   assign bus.err      = r_err;
endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: a 2-word and a 16-word instance share one stimulus
// stream (the small one sees the low address bit). A word-level model of
// each RAM is advanced on every clock and compared on every falling edge;
// directed sequences add literal expectations.
module tb_ram_param;
   localparam int W  = 8;
   localparam int A1 = 1;
   localparam int A4 = 4;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       en = 1'b0, rw = 1'b0, wipe = 1'b0;
   logic [3:0] addr = '0;
   logic [7:0] din = '0;

   always #5 clk = ~clk;

   ram_param_if #(.WIDTH(W), .ADDR_W(A1)) b1 ();
   ram_param_if #(.WIDTH(W), .ADDR_W(A4)) b4 ();

   assign b1.en      = en;
   assign b1.rw      = rw;
   assign b1.wipe    = wipe;
   assign b1.addr    = addr[0];
   assign b1.data_in = din;
   assign b4.en      = en;
   assign b4.rw      = rw;
   assign b4.wipe    = wipe;
   assign b4.addr    = addr;
   assign b4.data_in = din;

   ram_param #(.WIDTH(W), .ADDR_W(A1)) u_small (.clk(clk), .clr(clr), .bus(b1.slave));
   ram_param #(.WIDTH(W), .ADDR_W(A4)) u_big   (.clk(clk), .clr(clr), .bus(b4.slave));

   int n_vec = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each RAM: an array of words, a count of sweep cycles still to run,
   // and the last read word / strobes.
   logic [7:0] mm [2][16];
   int         left [2];
   int         depth [2] = '{2, 16};
   logic [7:0] md [2];
   logic       mv [2];
   logic       me [2];
   int         ma;

   always @(posedge clk or negedge clr) begin
      for (int k = 0; k < 2; k++) begin
         if (!clr) begin
            left[k] = depth[k];
            md[k]   = 8'h00;
            mv[k]   = 1'b0;
            me[k]   = 1'b0;
         end else begin
            ma    = (k == 0) ? int'(addr[0]) : int'(addr);
            mv[k] = 1'b0;
            me[k] = 1'b0;
            if (left[k] > 0) begin
               mm[k][depth[k] - left[k]] = 8'h00;
               left[k] = left[k] - 1;
               me[k]   = en;
            end else if (wipe) begin
               left[k] = depth[k];
            end else if (en && rw) begin
               mm[k][ma] = din;
            end else if (en) begin
               md[k] = mm[k][ma];
               mv[k] = 1'b1;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("dout_small",  b1.data_out, md[0]);
         check("valid_small", b1.valid,    mv[0]);
         check("busy_small",  b1.busy,     32'(left[0] > 0));
         check("err_small",   b1.err,      me[0]);
         check("dout_big",    b4.data_out, md[1]);
         check("valid_big",   b4.valid,    mv[1]);
         check("busy_big",    b4.busy,     32'(left[1] > 0));
         check("err_big",     b4.err,      me[1]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic apply(input logic e, input logic r, input logic w,
                        input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      en = e; rw = r; wipe = w; addr = a; din = d;
   endtask

   task automatic idle();
      apply(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
   endtask

   task automatic wait_big_idle();
      int n = 0;
      while (b4.busy === 1'b1 && n < 40) begin
         idle();
         n++;
      end
      check("sweep_timeout", b4.busy, 32'h0);
   endtask

   int cnt;

   initial begin
      // Reset: outputs take their reset values immediately.
      #1 clr = 1'b0;
      chk_on = 1'b1;
      #1;
      check("rst_busy",  b1.busy,     32'h1);
      check("rst_dout",  b1.data_out, 32'h00);
      check("rst_valid", b4.valid,    32'h0);
      check("rst_err",   b4.err,      32'h0);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;

      // Small RAM sweep lasts two cycles.
      idle();
      check("t1_busy_c1", b1.busy, 32'h1);
      idle();
      check("t1_busy_c2", b1.busy, 32'h0);
      wait_big_idle();
      apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
      apply(1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
      check("t1_rd0", b1.data_out, 32'h00);
      check("t1_rd0_v", b1.valid, 32'h1);
      idle();
      check("t1_rd1", b1.data_out, 32'h00);

      // Write two words, read them back.
      apply(1'b1, 1'b1, 1'b0, 4'h0, 8'hAA);
      apply(1'b1, 1'b1, 1'b0, 4'h1, 8'h55);
      apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
      check("t2_wr_novalid", b1.valid, 32'h0);
      apply(1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
      check("t2_rd0", b1.data_out, 32'hAA);
      check("t2_rd0_big", b4.data_out, 32'hAA);
      check("t2_rd0_v", b1.valid, 32'h1);
      idle();
      check("t2_rd1", b1.data_out, 32'h55);
      check("t2_rd1_v", b1.valid, 32'h1);
      idle();
      check("t2_hold", b1.data_out, 32'h55);
      check("t2_hold_v", b1.valid, 32'h0);

      // Write then read the same word on the next cycle.
      apply(1'b1, 1'b1, 1'b0, 4'h1, 8'h3C);
      apply(1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
      check("t3_wr_novalid", b1.valid, 32'h0);
      idle();
      check("t3_rd", b1.data_out, 32'h3C);

      // Wipe with a simultaneous write: write dropped, no err.
      apply(1'b1, 1'b1, 1'b0, 4'h0, 8'h11);
      apply(1'b1, 1'b1, 1'b0, 4'h1, 8'h22);
      apply(1'b1, 1'b1, 1'b1, 4'h0, 8'hFF);
      idle();
      check("t4_busy_c1", b1.busy, 32'h1);
      check("t4_err", b1.err, 32'h0);
      idle();
      check("t4_busy_c2", b1.busy, 32'h1);
      idle();
      check("t4_busy_end", b1.busy, 32'h0);
      apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
      apply(1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
      check("t4_rd0", b1.data_out, 32'h00);
      idle();
      check("t4_rd1", b1.data_out, 32'h00);
      wait_big_idle();

      // Access during a 16-word sweep: one err pulse, then all words zero.
      apply(1'b1, 1'b1, 1'b0, 4'h7, 8'h99);
      apply(1'b0, 1'b0, 1'b1, 4'h0, 8'h00);
      repeat (4) idle();
      apply(1'b1, 1'b0, 1'b0, 4'h3, 8'h00);
      idle();
      check("t5_err", b4.err, 32'h1);
      check("t5_busy", b4.busy, 32'h1);
      idle();
      check("t5_err_pulse", b4.err, 32'h0);
      wait_big_idle();
      for (int i = 0; i < 16; i++) begin
         apply(1'b1, 1'b0, 1'b0, 4'(i), 8'h00);
         idle();
         check("t5_word", b4.data_out, 32'h00);
      end

      // Reset mid-sweep.
      apply(1'b1, 1'b1, 1'b0, 4'h2, 8'h5A);
      apply(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
      idle();
      check("t6_pre", b4.data_out, 32'h5A);
      apply(1'b0, 1'b0, 1'b1, 4'h0, 8'h00);
      repeat (6) idle();
      #2 clr = 1'b0;
      #1;
      check("t6_async_dout", b4.data_out, 32'h00);
      check("t6_async_busy", b4.busy, 32'h1);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (b4.busy !== 1'b1) break;
         cnt++;
         idle();
      end
      check("t6_sweep_len", cnt, 32'd16);

      // Randomised traffic with occasional wipes and resets.
      for (int i = 0; i < 1500; i++) begin
         apply(($urandom_range(0, 9) < 6), $urandom_range(0, 1),
               ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
               8'($urandom));
         if ($urandom_range(0, 299) == 0) begin
            #3 clr = 1'b0;
            @(negedge clk);
            clr = 1'b1;
         end
      end
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
